i2s_adc_receiver: RTL and testbench

- Receives the WM8731 ADC serial stream in I2S format (MSB first, one-BCLK delay after each LRCK edge; LRCK low = left, high = right).
- Presents each stereo sample pair on a parallel valid/ready interface.
- Sits beside wm8731_controller, the audio-output path. The FPGA masters AUD_BCLK/AUD_ADCLRCK; this block only observes them and oversamples them in the system clock domain.

---
 rtl/i2s_adc_receiver_if.sv | 12 +
 rtl/i2s_adc_receiver.sv | 132 +++++++++++++
 tb/tb_i2s_adc_receiver.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/i2s_adc_receiver_if.sv
// rtl/i2s_adc_receiver_if.sv - parallel stereo sample handshake between receiver and consumer
interface i2s_adc_receiver_if #(
    parameter int WIDTH = 16
) ();
    logic [WIDTH-1:0] left;
    logic [WIDTH-1:0] right;
    logic             valid;
    logic             ready;

    modport master (output left, output right, output valid, input ready);
    modport slave  (input left, input right, input valid, output ready);
endinterface

// File: rtl/i2s_adc_receiver.sv
// rtl/i2s_adc_receiver.sv - oversampling I2S ADC receiver, delivers left/right pairs on a valid/ready port
module i2s_adc_receiver #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  bclk,
    input  logic                  lrclk,
    input  logic                  adcdat,
    i2s_adc_receiver_if.master    pcm,
    output logic                  overrun,
    output logic                  frame_err
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] bclk_sync;
    logic [SYNC_STAGES-1:0] lr_sync;
    logic [SYNC_STAGES-1:0] dat_sync;
    logic                   bclk_prev;
    logic                   lr_prev;
    logic                   have_prev;
    logic                   chan;
    logic                   left_ok;
    logic [CW-1:0]          bit_cnt;
    logic [WIDTH-2:0]       shreg;
    logic [WIDTH-1:0]       left_hold;
    logic [WIDTH-1:0]       left_q;
    logic [WIDTH-1:0]       right_q;
    logic                   valid_q;

    logic                   bclk_s;
    logic                   lr_s;
    logic                   dat_s;
    logic                   bclk_rise;
    logic                   frame_edge;
    logic                   word_done;
    logic                   pair_done;
    logic [WIDTH-1:0]       shift_next;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bclk_sync <= '0;
            lr_sync   <= '0;
            dat_sync  <= '0;
            bclk_prev <= 1'b0;
        end else begin
            bclk_sync <= {bclk_sync[SYNC_STAGES-2:0], bclk};
            lr_sync   <= {lr_sync[SYNC_STAGES-2:0], lrclk};
            dat_sync  <= {dat_sync[SYNC_STAGES-2:0], adcdat};
            bclk_prev <= bclk_sync[SYNC_STAGES-1];
        end
    end

    // have_prev keeps the first event after reset from counting as an LRCK edge
    always_comb begin
        bclk_s     = bclk_sync[SYNC_STAGES-1];
        lr_s       = lr_sync[SYNC_STAGES-1];
        dat_s      = dat_sync[SYNC_STAGES-1];
        bclk_rise  = bclk_s & ~bclk_prev;
        frame_edge = bclk_rise & have_prev & (lr_s != lr_prev);
        shift_next = {shreg, dat_s};
        word_done  = bclk_rise & ~frame_edge & (state == SHIFT) & (bit_cnt == CW'(WIDTH - 1));
        pair_done  = word_done & chan & left_ok;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            lr_prev   <= 1'b0;
            have_prev <= 1'b0;
            chan      <= 1'b0;
            left_ok   <= 1'b0;
            bit_cnt   <= '0;
            shreg     <= '0;
            left_hold <= '0;
            left_q    <= '0;
            right_q   <= '0;
            valid_q   <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (bclk_rise) begin
                lr_prev   <= lr_s;
                have_prev <= 1'b1;
            end

            // The frame-edge event is the I2S delay slot, so its data bit is never shifted in
            if (frame_edge) begin
                if (state == SHIFT) begin
                    frame_err <= 1'b1;
                end
                chan    <= lr_s;
                bit_cnt <= '0;
                shreg   <= '0;
                state   <= SHIFT;
                if (!lr_s) begin
                    left_ok <= 1'b0;
                end
            end else if (bclk_rise && state == SHIFT) begin
                shreg   <= shift_next[WIDTH-2:0];
                bit_cnt <= bit_cnt + CW'(1);
                if (word_done) begin
                    state <= HOLD;
                    if (!chan) begin
                        left_hold <= shift_next;
                        left_ok   <= 1'b1;
                    end
                end
            end

            if (pair_done) begin
                if (!valid_q || pcm.ready) begin
                    left_q  <= left_hold;
                    right_q <= shift_next;
                    valid_q <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (valid_q && pcm.ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign pcm.left  = left_q;
    assign pcm.right = right_q;
    assign pcm.valid = valid_q;
endmodule

// File: tb/tb_i2s_adc_receiver.sv
// tb/tb_i2s_adc_receiver.sv - self-checking bench for i2s_adc_receiver
module tb_i2s_adc_receiver;
    localparam int W   = 16;
    localparam int LAT = 3;

    logic clk     = 1'b0;
    logic reset_n = 1'b1;
    logic bclk    = 1'b0;
    logic lrclk   = 1'b1;
    logic adcdat  = 1'b0;
    logic overrun;
    logic frame_err;

    i2s_adc_receiver_if #(.WIDTH(W)) pcm ();

    i2s_adc_receiver #(.WIDTH(W), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bclk      (bclk),
        .lrclk     (lrclk),
        .adcdat    (adcdat),
        .pcm       (pcm.master),
        .overrun   (overrun),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic                valid_seen = 1'b0;
    int                  since_rise = 0;
    int                  last_lat   = -1;
    logic [2*W-1:0]      got_q[$];
    logic [2*W-1:0]      exp_q[$];

    always @(posedge bclk) since_rise = 0;

    always @(negedge clk) begin
        since_rise = since_rise + 1;
        if (pcm.valid && !valid_seen) begin
            got_q.push_back({pcm.left, pcm.right});
            last_lat = since_rise;
        end
        valid_seen = pcm.valid;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Called on a negedge of clk; returns on a negedge. One bclk period = 16 clk.
    task automatic bit_cycle(input logic lr, input logic d, input int rdy_at = -1);
        #2;
        bclk   = 1'b0;
        lrclk  = lr;
        adcdat = d;
        repeat (8) @(negedge clk);
        #2;
        bclk = 1'b1;
        if (rdy_at >= 0) begin
            repeat (rdy_at) @(negedge clk);
            pcm.ready = 1'b1;
            @(negedge clk);
            pcm.ready = 1'b0;
            repeat (7 - rdy_at) @(negedge clk);
        end else begin
            repeat (8) @(negedge clk);
        end
    endtask

    task automatic send_slot(input logic lr, input logic [31:0] word, input int n, input int rdy_at = -1);
        bit_cycle(lr, 1'($urandom));
        for (int i = 0; i < n; i++) begin
            bit_cycle(lr, word[31-i], (i == n - 1) ? rdy_at : -1);
        end
    endtask

    task automatic send_frame(input logic [31:0] l, input logic [31:0] r, input int nl, input int nr,
                              input int rdy_at = -1);
        send_slot(1'b0, l, nl);
        send_slot(1'b1, r, nr, rdy_at);
    endtask

    task automatic trailer();
        repeat (2) bit_cycle(1'b0, 1'b0);
    endtask

    task automatic do_reset(input logic rdy);
        pcm.ready = rdy;
        bclk      = 1'b0;
        lrclk     = 1'b1;
        @(negedge clk);
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        got_q.delete();
        last_lat = -1;
        repeat (3) bit_cycle(1'b1, 1'b0);
    endtask

    function automatic int pick_len();
        if ($urandom_range(0, 3) == 0) return int'($urandom_range(1, W - 1));
        return int'($urandom_range(W, 32));
    endfunction

    typedef struct {
        logic [31:0] l;
        logic [31:0] r;
        int          nl;
        int          nr;
        int          npairs;
        logic [15:0] el;
        logic [15:0] er;
        logic        err;
    } vec_t;

    vec_t vt[6];

    initial begin
        vt[0] = '{32'h8001_0000, 32'h7FFE_0000, 16, 16, 1, 16'h8001, 16'h7FFE, 1'b0};
        vt[1] = '{32'h0F0F_1234, 32'hF0F0_5678, 17, 20, 1, 16'h0F0F, 16'hF0F0, 1'b0};
        vt[2] = '{32'hDEAD_BEEF, 32'h0123_4567, 32, 32, 1, 16'hDEAD, 16'h0123, 1'b0};
        vt[3] = '{32'hA5A5_0000, 32'h5A5A_0000, 10, 16, 0, 16'h0000, 16'h0000, 1'b1};
        vt[4] = '{32'h1111_0000, 32'h2222_0000, 16, 15, 0, 16'h0000, 16'h0000, 1'b1};
        vt[5] = '{32'h0000_0000, 32'hFFFF_FFFF, 16, 16, 1, 16'h0000, 16'hFFFF, 1'b0};

        pcm.ready = 1'b1;
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_left", pcm.left, 0);
        check("reset_right", pcm.right, 0);
        check("reset_valid", pcm.valid, 0);
        check("reset_overrun", overrun, 0);
        check("reset_frame_err", frame_err, 0);

        for (int i = 0; i < 6; i++) begin
            do_reset(1'b1);
            send_frame(vt[i].l, vt[i].r, vt[i].nl, vt[i].nr);
            trailer();
            check($sformatf("vec%0d_pairs", i), got_q.size(), vt[i].npairs);
            check($sformatf("vec%0d_frame_err", i), frame_err, vt[i].err);
            check($sformatf("vec%0d_overrun", i), overrun, 0);
            if (vt[i].npairs == 1 && got_q.size() == 1) begin
                check($sformatf("vec%0d_left", i), got_q[0][2*W-1:W], vt[i].el);
                check($sformatf("vec%0d_right", i), got_q[0][W-1:0], vt[i].er);
                check($sformatf("vec%0d_latency", i), last_lat, LAT);
            end
        end

        // Short left slot, then a clean frame
        do_reset(1'b1);
        send_frame(32'hA5A5_0000, 32'h5A5A_0000, 10, 16);
        send_frame(32'h0F0F_0000, 32'hF0F0_0000, 16, 16);
        trailer();
        check("short_frame_err", frame_err, 1);
        check("short_pairs", got_q.size(), 1);
        if (got_q.size() == 1) check("short_pair", got_q[0], 32'h0F0F_F0F0);

        // Backpressure across two frames
        do_reset(1'b0);
        send_frame(32'h1234_0000, 32'h5678_0000, 16, 16);
        send_frame(32'hAAAA_0000, 32'h5555_0000, 16, 16);
        trailer();
        check("bp_valid", pcm.valid, 1);
        check("bp_left", pcm.left, 16'h1234);
        check("bp_right", pcm.right, 16'h5678);
        check("bp_overrun", overrun, 1);
        pcm.ready = 1'b1;
        @(negedge clk);
        pcm.ready = 1'b0;
        check("bp_valid_cleared", pcm.valid, 0);
        pcm.ready = 1'b1;
        repeat (4) @(negedge clk);
        check("bp_idle_ready", pcm.valid, 0);
        check("bp_overrun_sticky", overrun, 1);

        // Completion in the same cycle as acceptance
        do_reset(1'b0);
        send_frame(32'h1111_0000, 32'h2222_0000, 16, 16);
        check("sim_first_valid", pcm.valid, 1);
        send_frame(32'h3333_0000, 32'h4444_0000, 16, 16, 2);
        check("sim_valid", pcm.valid, 1);
        check("sim_left", pcm.left, 16'h3333);
        check("sim_right", pcm.right, 16'h4444);
        check("sim_overrun", overrun, 0);

        // Reset in the middle of a right word
        do_reset(1'b1);
        send_frame(32'hCAFE_0000, 32'hBEEF_0000, 16, 16);
        check("mid_first_pairs", got_q.size(), 1);
        send_slot(1'b0, 32'h9999_0000, 16);
        bit_cycle(1'b1, 1'b0);
        for (int i = 0; i < 8; i++) bit_cycle(1'b1, 1'($urandom));
        reset_n = 1'b0;
        #1;
        check("mid_reset_left", pcm.left, 0);
        check("mid_reset_right", pcm.right, 0);
        check("mid_reset_valid", pcm.valid, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        got_q.delete();
        for (int i = 0; i < 9; i++) bit_cycle(1'b1, 1'($urandom));
        send_frame(32'h1357_0000, 32'h2468_0000, 16, 16);
        trailer();
        check("mid_pairs", got_q.size(), 1);
        if (got_q.size() == 1) check("mid_pair", got_q[0], 32'h1357_2468);
        check("mid_frame_err", frame_err, 0);

        // Random frames against a slot-level model
        for (int round = 0; round < 3; round++) begin
            logic exp_err;
            do_reset(1'b1);
            exp_q.delete();
            exp_err = 1'b0;
            for (int f = 0; f < 6; f++) begin
                logic [31:0] l;
                logic [31:0] r;
                int nl;
                int nr;
                l  = $urandom;
                r  = $urandom;
                nl = pick_len();
                nr = pick_len();
                send_frame(l, r, nl, nr);
                if (nl >= W && nr >= W) exp_q.push_back({l[31:16], r[31:16]});
                if (nl < W || nr < W) exp_err = 1'b1;
            end
            trailer();
            check($sformatf("rnd%0d_pairs", round), got_q.size(), exp_q.size());
            for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
                check($sformatf("rnd%0d_pair%0d", round, k), got_q[k], exp_q[k]);
            end
            check($sformatf("rnd%0d_frame_err", round), frame_err, exp_err);
            check($sformatf("rnd%0d_overrun", round), overrun, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
